lcs_frame_requester: RTL and testbench

//  Initiator side of the LCS req/ack byte-fetch handshake. On start, walks FRAME_LEN consecutive
//  9-bit LCS addresses from BASE_ADDR: drives addr + req, waits for the responder's ack pulse,

---
 rtl/lcs_pkg.sv | 10 +
 rtl/sync_rise_det.sv | 11 +
 rtl/lcs_frame_requester.sv | 115 +++++++++++
 tb/tb_lcs_frame_requester.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcs_pkg.sv
// lcs_pkg: shared widths, error byte and FSM state encodings for the LCS byte-fetch requester.
package lcs_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam logic [DATA_W-1:0] ERR_BYTE = 8'hFF;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;
   localparam logic [1:0] GAP = 2'd3;
endpackage

// File: rtl/sync_rise_det.sv
// sync_rise_det: 2-flop synchronizer on an asynchronous level plus a one-cycle rising-edge pulse.
module sync_rise_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise
);
   logic [2:0] sr;
   always_ff @(posedge clk) sr <= rst ? 3'b000 : {sr[1:0], din};
   assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/lcs_frame_requester.sv
// lcs_frame_requester: walks FRAME_LEN LCS addresses with a req/ack handshake and streams the fetched bytes.
module lcs_frame_requester
   import lcs_pkg::*;
#(
   parameter int BASE_ADDR   = 184,
   parameter int FRAME_LEN   = 4,
   parameter int SETTLE_CYC  = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              req,
   output logic [ADDR_W-1:0] addr_lcs,
   input  logic              ack,
   input  logic [DATA_W-1:0] data_lcs,
   output logic [DATA_W-1:0] byte_data,
   output logic [ADDR_W-1:0] byte_idx,
   output logic              byte_valid,
   output logic              byte_err,
   output logic              busy,
   output logic              frame_done
);
   localparam int MAX_A = TIMEOUT_CYC > SETTLE_CYC ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int MAX_CYC = MAX_A > GAP_CYC ? MAX_A : GAP_CYC;
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   if (FRAME_LEN < 1 || BASE_ADDR + FRAME_LEN - 1 > 511) begin : g_badFrame
      $error("lcs_frame_requester: frame exceeds 9-bit LCS address space");
   end
   if (SETTLE_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 2) begin : g_badTiming
      $error("lcs_frame_requester: illegal timing parameters");
   end

   logic [1:0] state;
   logic [CNT_W-1:0] cnt;
   logic ackRise;

   sync_rise_det u_ackSync (.clk(clk), .rst(rst), .din(ack), .rise(ackRise));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         req <= 1'b0;
         addr_lcs <= BASE;
         byte_data <= '0;
         byte_idx <= '0;
         byte_valid <= 1'b0;
         byte_err <= 1'b0;
         busy <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               busy <= 1'b0;
               // the frame_done cycle is still part of the finished frame, so start is dropped there
               if (start && !frame_done) begin
                  state <= REQ;
                  cnt <= '0;
                  byte_idx <= '0;
                  addr_lcs <= BASE;
                  req <= 1'b1;
                  busy <= 1'b1;
               end
            end
            REQ: begin
               if (ackRise) begin
                  state <= SETTLE;
                  cnt <= '0;
               end else if (cnt == TMO_LAST) begin
                  state <= GAP;
                  cnt <= '0;
                  req <= 1'b0;
                  byte_data <= ERR_BYTE;
                  byte_err <= 1'b1;
                  byte_valid <= 1'b1;
               end else cnt <= cnt + CNT_W'(1);
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state <= GAP;
                  cnt <= '0;
                  req <= 1'b0;
                  byte_data <= data_lcs;
                  byte_err <= 1'b0;
                  byte_valid <= 1'b1;
               end else cnt <= cnt + CNT_W'(1);
            end
            default: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (byte_idx == LAST_IDX) begin
                     state <= IDLE;
                     frame_done <= 1'b1;
                  end else begin
                     state <= REQ;
                     byte_idx <= byte_idx + ADDR_W'(1);
                     addr_lcs <= addr_lcs + ADDR_W'(1);
                     req <= 1'b1;
                  end
               end else cnt <= cnt + CNT_W'(1);
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lcs_frame_requester.sv
// tb_lcs_frame_requester: scoreboard bench with a behavioural responder; a second instance covers the minimal frame.
module tb_lcs_frame_requester;
   localparam int SETTLE = 4;
   localparam int GAPC = 16;
   localparam int TMO = 255;
   localparam int BUDGET = 3000;

   typedef struct {
      int idx;
      logic [7:0] data;
      logic err;
      int cyc;
   } rec_t;

   logic clk = 0, rst = 1, start = 0, ack = 0;
   logic [7:0] data_lcs = 0;
   logic req, byte_valid, byte_err, busy, frame_done;
   logic [8:0] addr_lcs, byte_idx;
   logic [7:0] byte_data;

   logic start2 = 0, ack2 = 0;
   logic [7:0] data2 = 0;
   logic req2, bv2, be2, busy2, done2;
   logic [8:0] addr2, bi2;
   logic [7:0] bd2;

   int total = 0, bad = 0;
   int cyc = 0, doneCnt = 0, lowRun = 0, reqCnt = 0, silentAddr = -1;
   bit respOn = 1;
   logic reqPrev = 0;
   rec_t expQ[$], obsQ[$];
   int riseQ[$], gapQ[$];
   logic [8:0] addrQ[$];

   always #5 clk = ~clk;

   lcs_frame_requester #(.BASE_ADDR(184), .FRAME_LEN(4), .SETTLE_CYC(SETTLE), .GAP_CYC(GAPC), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .req(req), .addr_lcs(addr_lcs), .ack(ack), .data_lcs(data_lcs),
      .byte_data(byte_data), .byte_idx(byte_idx), .byte_valid(byte_valid), .byte_err(byte_err),
      .busy(busy), .frame_done(frame_done));

   lcs_frame_requester #(.BASE_ADDR(184), .FRAME_LEN(1), .SETTLE_CYC(1), .GAP_CYC(1), .TIMEOUT_CYC(TMO)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .req(req2), .addr_lcs(addr2), .ack(ack2), .data_lcs(data2),
      .byte_data(bd2), .byte_idx(bi2), .byte_valid(bv2), .byte_err(be2),
      .busy(busy2), .frame_done(done2));

   // responder: acks on the third low phase after req rises, drops ack once req falls
   always @(negedge clk) begin
      if (respOn) begin
         if (req) begin
            reqCnt++;
            if (reqCnt == 3 && int'(addr_lcs) != silentAddr) begin
               ack = 1;
               data_lcs = 8'hA0 + {6'd0, addr_lcs[1:0]};
            end
         end else begin
            reqCnt = 0;
            ack = 0;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (byte_valid) obsQ.push_back('{int'(byte_idx), byte_data, byte_err, cyc});
      if (frame_done) doneCnt++;
      if (req && !reqPrev) begin
         riseQ.push_back(cyc);
         addrQ.push_back(addr_lcs);
         gapQ.push_back(lowRun);
      end
      lowRun = req ? 0 : lowRun + 1;
      reqPrev = req;
   end

   task automatic clearAll();
      expQ.delete(); obsQ.delete(); riseQ.delete(); gapQ.delete(); addrQ.delete();
      doneCnt = 0;
   endtask

   task automatic pushFrame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] errs);
      expQ.push_back('{0, d0, errs[0], 0});
      expQ.push_back('{1, d1, errs[1], 0});
      expQ.push_back('{2, d2, errs[2], 0});
      expQ.push_back('{3, d3, errs[3], 0});
   endtask

   task automatic pulseStart();
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
   endtask

   task automatic waitFrame(output bit ok);
      int d0 = doneCnt;
      for (int i = 0; i < BUDGET && doneCnt == d0; i++) @(negedge clk);
      ok = doneCnt != d0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      total++;
      if ({req, byte_valid, byte_err, busy, frame_done} !== 5'b0 || addr_lcs !== 9'd184 || byte_idx !== 9'd0 || byte_data !== 8'd0) begin
         bad++;
         $display("FAIL reset: req=%b v=%b e=%b busy=%b done=%b addr=%0d idx=%0d data=%h, want 0s addr=184", req, byte_valid, byte_err, busy, frame_done, addr_lcs, byte_idx, byte_data);
      end
      rst = 0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_normal();
      bit ok;
      clearAll();
      pushFrame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000);
      pulseStart();
      waitFrame(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL normal_done_timeout: frame_done never seen"); end
      total++;
      if (obsQ.size() != 4 || doneCnt != 1) begin bad++; $display("FAIL normal_count: strobes=%0d done=%0d want 4/1", obsQ.size(), doneCnt); end
      for (int k = 0; k < 4 && k < obsQ.size(); k++) begin
         total++;
         if (obsQ[k].idx != expQ[k].idx || obsQ[k].data !== expQ[k].data || obsQ[k].err !== expQ[k].err) begin
            bad++;
            $display("FAIL normal_byte%0d: idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", k, obsQ[k].idx, obsQ[k].data, obsQ[k].err, expQ[k].idx, expQ[k].data, expQ[k].err);
         end
         total++;
         if (k < addrQ.size() && addrQ[k] !== 9'(184 + k)) begin bad++; $display("FAIL normal_addr%0d: got %0d want %0d", k, addrQ[k], 184 + k); end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      clearAll();
      silentAddr = 186;
      pushFrame(8'hA0, 8'hA1, 8'hFF, 8'hA3, 4'b0100);
      pulseStart();
      waitFrame(ok);
      silentAddr = -1;
      total++;
      if (!ok || obsQ.size() != 4) begin bad++; $display("FAIL timeout_count: done=%0b strobes=%0d want 1/4", ok, obsQ.size()); end
      for (int k = 0; k < 4 && k < obsQ.size(); k++) begin
         total++;
         if (obsQ[k].idx != expQ[k].idx || obsQ[k].data !== expQ[k].data || obsQ[k].err !== expQ[k].err) begin
            bad++;
            $display("FAIL timeout_byte%0d: idx=%0d data=%h err=%b want idx=%0d data=%h err=%b", k, obsQ[k].idx, obsQ[k].data, obsQ[k].err, expQ[k].idx, expQ[k].data, expQ[k].err);
         end
      end
      if (obsQ.size() > 2 && riseQ.size() > 2) begin
         total++;
         if (obsQ[2].cyc - riseQ[2] != TMO) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", obsQ[2].cyc - riseQ[2], TMO); end
      end
      for (int k = 1; k < 4 && k < gapQ.size(); k++) begin
         total++;
         if (gapQ[k] != GAPC) begin bad++; $display("FAIL timeout_gap%0d: req low %0d want %0d", k, gapQ[k], GAPC); end
      end
   endtask

   task automatic test_start_ignored();
      bit seen = 0;
      clearAll();
      pulseStart();
      repeat (20) @(negedge clk);
      pulseStart();
      for (int i = 0; i < BUDGET && !seen; i++) begin
         @(negedge clk);
         if (frame_done) begin
            seen = 1;
            start = 1;
            @(negedge clk) start = 0;
         end
      end
      repeat (40) @(negedge clk);
      total++;
      if (!seen || obsQ.size() != 4 || doneCnt != 1) begin bad++; $display("FAIL ignore_count: done_seen=%0b strobes=%0d done=%0d want 1/4/1", seen, obsQ.size(), doneCnt); end
      total++;
      if (busy !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL ignore_idle: busy=%b req=%b want 0/0", busy, req); end
      for (int k = 0; k < obsQ.size(); k++) begin
         total++;
         if (obsQ[k].idx != k) begin bad++; $display("FAIL ignore_idx%0d: got %0d want %0d", k, obsQ[k].idx, k); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit found = 0;
      clearAll();
      pulseStart();
      for (int i = 0; i < BUDGET && !found; i++) begin
         @(negedge clk);
         found = req && addr_lcs == 9'd185;
      end
      repeat (6) @(negedge clk);
      rst = 1;
      @(negedge clk);
      total++;
      if (!found || req !== 1'b0 || busy !== 1'b0 || byte_valid !== 1'b0 || frame_done !== 1'b0) begin
         bad++;
         $display("FAIL midreset_outputs: found=%0b req=%b busy=%b v=%b done=%b want 1/0/0/0/0", found, req, busy, byte_valid, frame_done);
      end
      rst = 0;
      repeat (30) @(negedge clk);
      total++;
      if (obsQ.size() != 1 || doneCnt != 0) begin bad++; $display("FAIL midreset_quiet: strobes=%0d done=%0d want 1/0", obsQ.size(), doneCnt); end
      clearAll();
      pushFrame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 4'b0000);
      pulseStart();
      waitFrame(ok);
      total++;
      if (!ok || obsQ.size() != 4 || addrQ.size() < 1 || addrQ[0] !== 9'd184) begin
         bad++;
         $display("FAIL midreset_restart: done=%0b strobes=%0d first_addr=%0d want 1/4/184", ok, obsQ.size(), addrQ.size() > 0 ? int'(addrQ[0]) : -1);
      end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         rec_t e = expQ.pop_front();
         rec_t o = obsQ.pop_front();
         total++;
         if (o.idx != e.idx || o.data !== e.data || o.err !== e.err) begin
            bad++;
            $display("FAIL midreset_byte%0d: data=%h err=%b idx=%0d want data=%h err=%b", e.idx, o.data, o.err, o.idx, e.data, e.err);
         end
      end
   endtask

   task automatic test_held_ack();
      bit ok;
      bit found = 0;
      clearAll();
      respOn = 0;
      ack = 1;
      data_lcs = 8'h00;
      repeat (5) @(negedge clk);
      expQ.push_back('{0, 8'(8'h40 + SETTLE + 2), 1'b0, 0});
      expQ.push_back('{1, 8'hA1, 1'b0, 0});
      expQ.push_back('{2, 8'hA2, 1'b0, 0});
      expQ.push_back('{3, 8'hA3, 1'b0, 0});
      pulseStart();
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         found = req;
      end
      repeat (5) @(negedge clk);
      ack = 0;
      repeat (2) @(negedge clk);
      ack = 1;
      data_lcs = 8'h40;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         data_lcs = 8'(8'h40 + n);
      end
      respOn = 1;
      waitFrame(ok);
      total++;
      if (!found || !ok || obsQ.size() != 4) begin bad++; $display("FAIL heldack_count: req=%0b done=%0b strobes=%0d want 1/1/4", found, ok, obsQ.size()); end
      while (expQ.size() > 0 && obsQ.size() > 0) begin
         rec_t e = expQ.pop_front();
         rec_t o = obsQ.pop_front();
         total++;
         if (o.idx != e.idx || o.data !== e.data || o.err !== e.err) begin
            bad++;
            $display("FAIL heldack_byte%0d: data=%h err=%b idx=%0d want data=%h err=%b", e.idx, o.data, o.err, o.idx, e.data, e.err);
         end
      end
   endtask

   task automatic test_min_frame();
      int vCyc = -1, dCyc = -1, nValid = 0, nDone = 0;
      bit found = 0;
      logic [7:0] got = 0;
      logic busyAtDone = 0;
      @(negedge clk) start2 = 1;
      @(negedge clk) start2 = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         found = req2;
         if (!found) @(negedge clk);
      end
      total++;
      if (!found || addr2 !== 9'd184) begin bad++; $display("FAIL min_req: req=%b addr=%0d want 1/184", req2, addr2); end
      ack2 = 1;
      data2 = 8'h5A;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bv2) begin nValid++; vCyc = cyc; got = bd2; end
         if (done2) begin nDone++; dCyc = cyc; busyAtDone = busy2; end
         if (!req2) ack2 = 0;
      end
      total++;
      if (nValid != 1 || nDone != 1 || got !== 8'h5A || be2 !== 1'b0 || bi2 !== 9'd0) begin
         bad++;
         $display("FAIL min_byte: valids=%0d dones=%0d data=%h err=%b idx=%0d want 1/1/5a/0/0", nValid, nDone, got, be2, bi2);
      end
      total++;
      if (dCyc - vCyc != 1) begin bad++; $display("FAIL min_done_latency: got %0d want 1", dCyc - vCyc); end
      total++;
      if (busyAtDone !== 1'b1 || busy2 !== 1'b0) begin bad++; $display("FAIL min_busy: at_done=%b after=%b want 1/0", busyAtDone, busy2); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_timeout();
      test_start_ignored();
      test_reset_mid();
      test_held_ack();
      test_min_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
